twiddle_sched: RTL and testbench
================================

Name: twiddle_sched

Overview:
- Sequencer for the NTT twiddle RAM. In LOAD it streams N/2 twiddle factors into the RAM. In RUN it walks every stage and butterfly of an N-point radix-2 DIT NTT and presents the matching twiddle to the butterfly unit over a valid/ready handshake.
- Sits between the host/config loader and the twiddle RAM on one side, and the butterfly datapath on the other.

Parameters:
- W, 32, twiddle word width.
- N, 16, NTT points; power of two, ≥4.
- DEPTH, N/2, twiddle RAM depth (derived; do not override).
- AW, clog2(DEPTH), RAM address width.
- LOGN, clog2(N), number of stages.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  twiddle word valid.
- load_data  in  W  twiddle word; words arrive in index order 0..DEPTH-1.
- load_ready  out  1  accepts a load word.
- start  in  1  one-cycle pulse; begin a RUN pass.
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle pulse after the last twiddle handshake.
- err_start  out  1  sticky; start seen while the RAM is not full or the block is busy.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  W  RAM write data.
- ram_raddr  out  AW  RAM read address.
- ram_rdata  in  W  RAM read data; combinational from ram_raddr.
- ram_full  in  1  RAM all-written flag.
- tw_valid  out  1  twiddle valid to butterfly.
- tw_ready  in  1  butterfly accepts.
- tw_data  out  W  twiddle value (= ram_rdata).
- tw_stage  out  clog2(LOGN)  current stage s.
- tw_bfly  out  LOGN-1  butterfly index j within the stage.
- tw_last  out  1  final butterfly of the final stage.

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0. load_ready=0, busy=0, done=0, err_start=0, ram_we=0, ram_waddr=0, ram_raddr=0, tw_valid=0, tw_stage=0, tw_bfly=0, tw_last=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If ram_full=0: go to LOAD next cycle.
  - Else if start: go to RUN.
- LOAD:
  - load_ready=1.
  - On load_valid&&load_ready: ram_we=1, ram_waddr=wcnt, ram_wdata=load_data (combinational, same cycle); then wcnt++.
  - When wcnt reaches DEPTH-1 with a handshake: wcnt wraps to 0, go to IDLE.
  - load_valid=0 stalls without writing.
- RUN:
  - tw_valid=1.
  - ram_raddr = (j mod 2^s) << (LOGN-1-s), computed in AW bits.
  - tw_data=ram_rdata in the same cycle (zero latency).
  - Advance only on tw_valid&&tw_ready. j counts 0..N/2-1; on wrap, s++.
  - tw_last=1 when s=LOGN-1 and j=N/2-1.
  - Handshake on tw_last: go to DONE.
  - tw_ready=0 holds all outputs stable.
- DONE: done=1 for exactly one cycle, counters cleared, go to IDLE.
- busy=1 in LOAD and RUN.
- start rules:
  - start ignored in LOAD, RUN and DONE; it sets err_start.
  - start in IDLE with ram_full=0 sets err_start and the block enters LOAD.
  - err_start clears only on reset.
- Total RUN handshakes = LOGN·N/2.
- Reset asserted mid-LOAD or mid-RUN: immediate return to IDLE, no further ram_we. RAM contents and its flags are owned by the RAM.

Optional Feature:
- Macro: TWIDDLE_SCHED_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits). It increments each RUN cycle with tw_valid=1 and tw_ready=0, saturates at 0xFFFF, clears on start acceptance and on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, ram_full=0, stream 8 words 0x100..0x107 with N=16 -> ram_we pulses at addresses 0..7 with matching data; load_ready drops; state IDLE.
- ram_full=1, start, tw_ready=1, N=16 -> 32 handshakes.
  - Stage 0: raddr all 0.
  - Stage 1: 0,4,0,4,…
  - Stage 2: 0,2,4,6,…
  - Stage 3: 0..7.
  - tw_last on the 32nd handshake; done one cycle later.
- RUN with tw_ready toggling 1,0,0,1 -> addresses and tw_data held during stalls; total handshakes still 32; stall_cnt=2 per stall pair when the macro is defined.
- start while ram_full=0 -> err_start=1 and stays 1; block enters LOAD; no tw_valid.
- rst=0 asserted after 3 load writes -> all outputs at reset values asynchronously. After release, LOAD restarts at address 0.
- start pulsed during RUN -> err_start=1; sequence unaffected; done still after 32 handshakes.

Source files
------------

// File: rtl/twiddle_sched.sv
// twiddle_sched: sequencer for the NTT twiddle RAM.
//   LOAD: streams DEPTH = N/2 twiddle words into the RAM in index order.
//   RUN : walks every stage s and butterfly j of an N-point radix-2 DIT NTT.
//         It presents twiddle[(j mod 2^s) << (LOGN-1-s)] to the butterfly unit
//         over a valid/ready handshake.
// Ports:
//   clk, rst (async, active-low)
//   load_valid/load_ready/load_data : twiddle load stream
//   start                           : begin a RUN pass (needs ram_full, block idle)
//   busy, done, err_start           : status (err_start is sticky until reset)
//   ram_we/ram_waddr/ram_wdata      : RAM write port
//   ram_raddr/ram_rdata, ram_full   : RAM read port (combinational) and full flag
//   tw_valid/tw_ready/tw_data       : twiddle stream to the butterfly
//   tw_stage/tw_bfly/tw_last        : position tags for the current twiddle
// Optional: define TWIDDLE_SCHED_STALL_CNT_EN to add stall_cnt[15:0].
//   It counts RUN cycles with tw_ready low, saturates at 0xFFFF, and clears on
//   start acceptance and on reset.
module twiddle_sched #(
  parameter  int unsigned W     = 32,
  parameter  int unsigned N     = 16,
  localparam int unsigned DEPTH = N / 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LOGN  = $clog2(N),
  localparam int unsigned SW    = $clog2(LOGN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [W-1:0]  load_data,
  output logic          load_ready,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err_start,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [W-1:0]  ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [W-1:0]  ram_rdata,
  input  logic          ram_full,
  output logic          tw_valid,
  input  logic          tw_ready,
  output logic [W-1:0]  tw_data,
  output logic [SW-1:0] tw_stage,
  output logic [AW-1:0] tw_bfly,
  output logic          tw_last
`ifdef TWIDDLE_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [AW-1:0] bfly_q, bfly_d;
  logic          err_q, err_d;

  logic          is_last;
  logic [AW-1:0] mask;
  logic [AW-1:0] raddr;
  logic [31:0]   shamt;

  assign is_last = (stage_q == SW'(LOGN - 1)) && (bfly_q == AW'(DEPTH - 1));

  // (j mod 2^s) << (LOGN-1-s). At s = AW the shift of 1 wraps to 0, so the
  // mask becomes all ones, which is exactly "mod 2^AW".
  always_comb begin
    mask  = (AW'(1) << stage_q) - AW'(1);
    shamt = AW - 32'(stage_q);
    raddr = (bfly_q & mask) << shamt;
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    stage_d    = stage_q;
    bfly_d     = bfly_q;
    err_d      = err_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ram_we     = 1'b0;
    tw_valid   = 1'b0;
    tw_last    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!ram_full) begin
          state_d = StLoad;
          if (start) err_d = 1'b1;
        end else if (start) begin
          state_d = StRun;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (start) err_d = 1'b1;
        if (load_valid) begin
          ram_we = 1'b1;
          if (wcnt_q == AW'(DEPTH - 1)) begin
            wcnt_d  = '0;
            state_d = StIdle;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        busy     = 1'b1;
        tw_valid = 1'b1;
        tw_last  = is_last;
        if (start) err_d = 1'b1;
        if (tw_ready) begin
          if (bfly_q == AW'(DEPTH - 1)) begin
            bfly_d = '0;
            if (is_last) begin
              stage_d = '0;
              state_d = StDone;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            bfly_d = bfly_q + 1'b1;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        if (start) err_d = 1'b1;
        wcnt_d  = '0;
        stage_d = '0;
        bfly_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ram_waddr = wcnt_q;
  assign ram_wdata = load_data;
  assign ram_raddr = (state_q == StRun) ? raddr : '0;
  assign tw_data   = ram_rdata;
  assign tw_stage  = stage_q;
  assign tw_bfly   = bfly_q;
  assign err_start = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      err_q   <= err_d;
    end
  end

`ifdef TWIDDLE_SCHED_STALL_CNT_EN
  logic        start_ok;
  logic [15:0] stall_q, stall_d;

  assign start_ok = (state_q == StIdle) && ram_full && start;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if ((state_q == StRun) && !tw_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_twiddle_sched.sv
// Self-checking bench for twiddle_sched (N=16, W=32) with a behavioural RAM and
// an index-arithmetic reference for the twiddle walk.
module tb_twiddle_sched;

  localparam int unsigned W     = 32;
  localparam int unsigned N     = 16;
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned LOGN  = $clog2(N);
  localparam int unsigned AW    = $clog2(HALF);
  localparam int unsigned SW    = $clog2(LOGN);
  localparam int unsigned TOTAL = LOGN * HALF;

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic [W-1:0]  load_data;
  logic          load_ready;
  logic          start;
  logic          busy;
  logic          done;
  logic          err_start;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [W-1:0]  ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [W-1:0]  ram_rdata;
  logic          ram_full;
  logic          tw_valid;
  logic          tw_ready;
  logic [W-1:0]  tw_data;
  logic [SW-1:0] tw_stage;
  logic [AW-1:0] tw_bfly;
  logic          tw_last;
`ifdef TWIDDLE_SCHED_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int            n_total;
  int            n_bad;
  bit            err_exp;
  logic [W-1:0]  exp_tw [HALF];
  logic [W-1:0]  mem    [HALF];

  twiddle_sched #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err_start  (err_start),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .ram_full   (ram_full),
    .tw_valid   (tw_valid),
    .tw_ready   (tw_ready),
    .tw_data    (tw_data),
    .tw_stage   (tw_stage),
    .tw_bfly    (tw_bfly),
    .tw_last    (tw_last)
`ifdef TWIDDLE_SCHED_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural twiddle RAM: synchronous write, combinational read.
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Twiddle index for the k-th handshake: stage s = k / (N/2), butterfly j.
  function automatic int unsigned exp_addr(input int unsigned k);
    int unsigned s, j;
    s = k / HALF;
    j = k % HALF;
    return (j % (1 << s)) * (HALF >> s);
  endfunction

  task automatic do_load(input int unsigned n_acc);
    int unsigned acc;
    int          cyc;
    bit          v;
    acc        = 0;
    cyc        = 0;
    load_valid = 1'b0;
    @(negedge clk);
    while (!load_ready && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    check("load_enter", 64'(load_ready), 64'd1);
    cyc = 0;
    while (acc < n_acc && cyc < 200) begin
      v          = ($urandom_range(0, 3) != 0);
      load_valid = v;
      load_data  = v ? exp_tw[acc] : $urandom();
      #1;
      check("load_ready", 64'(load_ready), 64'd1);
      check("load_busy", 64'(busy), 64'd1);
      check("load_we", 64'(ram_we), 64'(v));
      if (v) begin
        check("load_addr", 64'(ram_waddr), 64'(acc));
        check("load_data", 64'(ram_wdata), 64'(exp_tw[acc]));
      end
      @(posedge clk);
      #1;
      if (v) acc++;
      cyc++;
      if (acc < n_acc) @(negedge clk);
    end
    load_valid = 1'b0;
    if (acc != n_acc) check("load_timeout", 64'(acc), 64'(n_acc));
    if (n_acc == HALF) begin
      ram_full = 1'b1;
      @(negedge clk);
      check("load_end_ready", 64'(load_ready), 64'd0);
      check("load_end_busy", 64'(busy), 64'd0);
      check("load_end_we", 64'(ram_we), 64'd0);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_pass(input int mode, input bit inject);
    int unsigned k;
    int          cyc;
    int          stalls;
    bit          rdy;
    int unsigned a;
    k      = 0;
    cyc    = 0;
    stalls = 0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (k < TOTAL && cyc < 1000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tw_ready = rdy;
      start    = inject && (cyc == 7);
      if (start) err_exp = 1'b1;
      @(negedge clk);
      a = exp_addr(k);
      check("run_valid", 64'(tw_valid), 64'd1);
      check("run_busy", 64'(busy), 64'd1);
      check("run_done", 64'(done), 64'd0);
      check("run_raddr", 64'(ram_raddr), 64'(a));
      check("run_data", 64'(tw_data), 64'(exp_tw[a]));
      check("run_stage", 64'(tw_stage), 64'(k / HALF));
      check("run_bfly", 64'(tw_bfly), 64'(k % HALF));
      check("run_last", 64'(tw_last), 64'(k == TOTAL - 1));
      if (rdy) k++;
      else stalls++;
      @(posedge clk);
      #1;
      cyc++;
    end
    start    = 1'b0;
    tw_ready = 1'b0;
    if (k != TOTAL) check("run_timeout", 64'(k), 64'(TOTAL));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_valid", 64'(tw_valid), 64'd0);
    @(negedge clk);
    check("done_once", 64'(done), 64'd0);
    check("run_err", 64'(err_start), 64'(err_exp));
`ifdef TWIDDLE_SCHED_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, 64'({load_ready, busy, done, err_start, ram_we, ram_waddr, ram_raddr,
                    tw_valid, tw_stage, tw_bfly, tw_last}), 64'd0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    err_exp    = 1'b0;
    rst        = 1'b1;
    ram_full   = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    tw_ready   = 1'b0;
    for (int i = 0; i < HALF; i++) exp_tw[i] = 32'h100 + 32'(i);
    #2 rst = 1'b0;
    #16;
    check_reset_outs("reset_outs");
`ifdef TWIDDLE_SCHED_STALL_CNT_EN
    check("reset_stall", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Load 0x100..0x107, then idle with the RAM full.
    do_load(HALF);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(tw_valid), 64'd0);

    run_pass(0, 1'b0);
    run_pass(1, 1'b0);
    run_pass(2, 1'b0);
    run_pass(2, 1'b1);

    // Reset clears err_start; start while not full flags an error and loads.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_err_clear", 64'(err_start), 64'd0);
    err_exp  = 1'b0;
    ram_full = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("nf_start_err", 64'(err_start), 64'd1);
    check("nf_start_load", 64'(load_ready), 64'd1);
    check("nf_start_valid", 64'(tw_valid), 64'd0);

    // Partial load then asynchronous reset mid-LOAD.
    for (int i = 0; i < HALF; i++) exp_tw[i] = $urandom();
    do_load(3);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs("midload_reset");
`ifdef TWIDDLE_SCHED_STALL_CNT_EN
    check("midload_stall", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    do_load(HALF);
    run_pass(2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
